clmul32_karatsuba_seq: RTL and testbench
========================================

// Module: clmul32_karatsuba_seq
// PURPOSE
// Sequential 32x32 carry-less (GF(2)[x]) multiplier. A single shared 16x16 carry-less multiplier core is
// time-multiplexed over the three Karatsuba partial products:
//   z0 = a_lo*b_lo,  z2 = a_hi*b_hi,  z1 = (a_lo^a_hi)*(b_lo^b_hi)
// An XOR overlap-sum stage then combines them:
//   p = (z2<<2H) ^ ((z0^z1^z2)<<H) ^ z0
// The block sequences the core and the combiner, and sits between a valid/ready operand source and result sink.
// PARAMETERS
// HALF_W  16  half-operand width H; operands 2H bits, partial products 2H-1 bits, product 4H-1 bits
// PORTS
// clk        in   1        single clock, rising edge
// rst        in   1        synchronous, active-high reset
// in_valid   in   1        operand pair valid
// in_ready   out  1        block can accept operands this cycle
// in_a       in   2*H      operand A (a_hi = [2H-1:H], a_lo = [H-1:0])
// in_b       in   2*H      operand B
// out_valid  out  1        product valid
// out_ready  in   1        sink accepts product this cycle
// out_p      out  4*H-1    carry-less product A*B
// busy       out  1        high in any state other than IDLE
// BEHAVIOUR
// - Reset (sync, rst=1 at posedge): state<=IDLE; out_valid=0, out_p=0, busy=0; operand/partial regs cleared.
//   Reset dominates every other event, including a handshake in the same cycle.
// - FSM states: IDLE -> MUL_LO -> MUL_HI -> MUL_MID -> OUT.
//   IDLE: in_ready=1. On in_valid&in_ready, latch in_a/in_b and go to MUL_LO.
//   MUL_LO: core fed a_lo,b_lo; z0 registered; go to MUL_HI.
//   MUL_HI: core fed a_hi,b_hi; z2 registered; go to MUL_MID.
//   MUL_MID: core fed a_lo^a_hi, b_lo^b_hi; the overlap-sum uses the core output directly as z1;
//     out_p is registered; out_valid<=1; go to OUT.
//   OUT: out_valid=1; out_p held stable while out_ready=0 (no change allowed under backpressure).
//     out_ready=0: stay in OUT.
//     out_ready=1 and in_valid=0: go to IDLE; out_valid<=0.
//     out_ready=1 and in_valid=1: in_ready=1 (combinational on out_ready); latch new operands and go to MUL_LO.
//       The result and the new operands are exchanged in the same cycle.
// - in_ready = (state==IDLE) | (state==OUT & out_ready). It is never asserted in MUL_* states; in_a/in_b are
//   ignored there.
// - Latency: operands accepted at edge T -> out_valid=1 after edge T+3 (3 core cycles).
//   Sustained throughput is 1 product per 4 cycles when out_ready=1.
// - The core is a purely combinational 16x16 clmul. Its inputs are muxed by state and are zero in IDLE/OUT
//   (power). Exactly one core evaluation per MUL_* cycle.
// - Width rules: all arithmetic is XOR/AND over GF(2); no carries.
//   z0, z1, z2 are 2H-1 bits; middle term (z0^z1^z2) is 2H-1 bits placed at bit H; z2 is placed at bit 2H.
//   out_p bits [4H-2:0] are fully defined.
// - in_valid held with unchanged data while in_ready=0 is required of the source. The block does not buffer
//   more than one operand pair.
// - Reset in any MUL_* or OUT state abandons the operation: no out_valid pulse follows the reset.
// TESTING
// T1 a=0x00000001,b=0x00000001 -> out_p=0x0000000000000001, out_valid exactly 4 edges after accept.
// T2 a=0x00010000,b=0x00010000 -> out_p=0x0000000100000000 (pure z2 path);
//    a=0x00000003,b=0x00000003 -> 0x5.
// T3 a=0xFFFFFFFF,b=0xFFFFFFFF -> out_p=0x5555555555555555;
//    a=0x80000000,b=0x80000000 -> 0x4000000000000000.
// T4 Backpressure: hold out_ready=0 for 10 cycles in OUT -> out_p/out_valid stable, in_ready=0;
//    release -> single transfer.
// T5 Back-to-back: in_valid=1 continuously, out_ready=1 -> accepts every 4 cycles;
//    1000 random pairs match a bitwise clmul reference model.
// T6 Assert rst during MUL_HI -> next cycle IDLE, out_valid=0, in_ready=1;
//    the following operation returns a correct result.

Source files
------------

// File: rtl/clmul32_karatsuba_seq.sv
// Sequential 2H x 2H carry-less multiplier: one shared H x H clmul core is stepped over the
// three Karatsuba partial products, then an XOR overlap-sum forms the 4H-1 bit product.
module clmul32_karatsuba_seq #(
  parameter int HALF_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2*HALF_W-1:0]   in_a,
  input  logic [2*HALF_W-1:0]   in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*HALF_W-2:0]   out_p,
  output logic                  busy
);

  localparam int OP_W   = 2 * HALF_W;
  localparam int PP_W   = 2 * HALF_W - 1;
  localparam int PROD_W = 4 * HALF_W - 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MUL_LO  = 3'd1,
    ST_MUL_HI  = 3'd2,
    ST_MUL_MID = 3'd3,
    ST_OUT     = 3'd4
  } state_t;

  // Shared combinational H x H carry-less core: shifted copies of x gated by each bit of y.
  function automatic logic [PP_W-1:0] clmul_half(input logic [HALF_W-1:0] x,
                                                 input logic [HALF_W-1:0] y);
    logic [PP_W-1:0] acc;
    acc = {PP_W{1'b0}};
    for (int i = 0; i < HALF_W; i++) begin
      acc = acc ^ (({{(HALF_W-1){1'b0}}, x} & {PP_W{y[i]}}) << i);
    end
    return acc;
  endfunction

  // Karatsuba overlap-sum; the middle term needs no sign fix-up because GF(2) subtraction is XOR.
  function automatic logic [PROD_W-1:0] overlap_sum(input logic [PP_W-1:0] z0,
                                                    input logic [PP_W-1:0] z1,
                                                    input logic [PP_W-1:0] z2);
    logic [PP_W-1:0] mid;
    mid = z0 ^ z1 ^ z2;
    return {z2, {OP_W{1'b0}}}
         ^ {{HALF_W{1'b0}}, mid, {HALF_W{1'b0}}}
         ^ {{OP_W{1'b0}}, z0};
  endfunction

  state_t              state_r;
  logic [OP_W-1:0]     a_r;
  logic [OP_W-1:0]     b_r;
  logic [PP_W-1:0]     z0_r;
  logic [PP_W-1:0]     z2_r;
  logic [PROD_W-1:0]   out_p_r;
  logic                out_valid_r;
  logic                busy_r;

  logic [HALF_W-1:0]   core_x_s;
  logic [HALF_W-1:0]   core_y_s;
  logic [PP_W-1:0]     core_p_s;
  logic [PROD_W-1:0]   prod_s;
  logic                in_ready_s;
  logic                accept_s;

  // Core operand select; held at zero outside the MUL states so the core does not toggle.
  always_comb begin
    core_x_s = {HALF_W{1'b0}};
    core_y_s = {HALF_W{1'b0}};
    case (state_r)
      ST_MUL_LO: begin
        core_x_s = a_r[HALF_W-1:0];
        core_y_s = b_r[HALF_W-1:0];
      end
      ST_MUL_HI: begin
        core_x_s = a_r[OP_W-1:HALF_W];
        core_y_s = b_r[OP_W-1:HALF_W];
      end
      ST_MUL_MID: begin
        core_x_s = a_r[HALF_W-1:0] ^ a_r[OP_W-1:HALF_W];
        core_y_s = b_r[HALF_W-1:0] ^ b_r[OP_W-1:HALF_W];
      end
      default: begin
        core_x_s = {HALF_W{1'b0}};
        core_y_s = {HALF_W{1'b0}};
      end
    endcase
  end

  // Core output, final combine (z1 taken straight from the core) and the input handshake.
  always_comb begin
    core_p_s   = clmul_half(core_x_s, core_y_s);
    prod_s     = overlap_sum(z0_r, core_p_s, z2_r);
    in_ready_s = (state_r == ST_IDLE) | ((state_r == ST_OUT) & out_ready);
    accept_s   = in_valid & in_ready_s;
  end

  // Sequencer FSM with registered product, valid and busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      a_r         <= {OP_W{1'b0}};
      b_r         <= {OP_W{1'b0}};
      z0_r        <= {PP_W{1'b0}};
      z2_r        <= {PP_W{1'b0}};
      out_p_r     <= {PROD_W{1'b0}};
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r     <= in_a;
            b_r     <= in_b;
            state_r <= ST_MUL_LO;
            busy_r  <= 1'b1;
          end
        end
        ST_MUL_LO: begin
          z0_r    <= core_p_s;
          state_r <= ST_MUL_HI;
        end
        ST_MUL_HI: begin
          z2_r    <= core_p_s;
          state_r <= ST_MUL_MID;
        end
        ST_MUL_MID: begin
          out_p_r     <= prod_s;
          out_valid_r <= 1'b1;
          state_r     <= ST_OUT;
        end
        ST_OUT: begin
          // Result leaves and, if offered, the next operand pair enters on the same edge.
          if (out_ready) begin
            out_valid_r <= 1'b0;
            if (in_valid) begin
              a_r     <= in_a;
              b_r     <= in_b;
              state_r <= ST_MUL_LO;
            end else begin
              state_r <= ST_IDLE;
              busy_r  <= 1'b0;
            end
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          out_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_p     = out_p_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_clmul32_karatsuba_seq.sv
// Self-checking bench for clmul32_karatsuba_seq: directed corner products, backpressure,
// back-to-back random streaming against a plain shift-and-XOR model, and mid-operation reset.
module tb_clmul32_karatsuba_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        out_valid;
  logic        out_ready;
  logic [62:0] out_p;
  logic        busy;

  int n_checks;
  int n_fail;

  clmul32_karatsuba_seq #(.HALF_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: full-width schoolbook carry-less product.
  function automatic logic [62:0] ref_clmul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < 32; i++)
      if (b[i]) r = r ^ ({32'd0, a} << i);
    return r[62:0];
  endfunction

  // One operation from IDLE; lat counts edges from the accepting edge (inclusive) to out_valid.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output logic [62:0] p, output int lat);
    int guard;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    guard = 0;
    while (!in_ready && guard < 16) begin
      @(posedge clk); #1; guard++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    lat = 1;
    while (!out_valid && lat < 16) begin
      @(posedge clk); #1; lat++;
    end
    p = out_p;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h9abc_def0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    n_checks++; if (out_p !== 63'd0) begin n_fail++; $display("FAIL reset_out_p got %h want 0", out_p); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_directed();
    logic [31:0] ta [6];
    logic [31:0] tb [6];
    logic [62:0] tp [6];
    logic [62:0] p;
    int lat;
    ta[0] = 32'h0000_0001; tb[0] = 32'h0000_0001; tp[0] = 63'h0000000000000001;
    ta[1] = 32'h0001_0000; tb[1] = 32'h0001_0000; tp[1] = 63'h0000000100000000;
    ta[2] = 32'h0000_0003; tb[2] = 32'h0000_0003; tp[2] = 63'h0000000000000005;
    ta[3] = 32'hFFFF_FFFF; tb[3] = 32'hFFFF_FFFF; tp[3] = 63'h5555555555555555;
    ta[4] = 32'h8000_0000; tb[4] = 32'h8000_0000; tp[4] = 63'h4000000000000000;
    ta[5] = 32'h0001_0001; tb[5] = 32'h0000_0003; tp[5] = 63'h0000000000030003;
    for (int k = 0; k < 6; k++) begin
      run_op(ta[k], tb[k], p, lat);
      n_checks++;
      if (p !== tp[k]) begin
        n_fail++; $display("FAIL directed_%0d product got %h want %h", k, p, tp[k]);
      end
      n_checks++;
      if (lat != 4) begin
        n_fail++; $display("FAIL directed_%0d latency got %0d want 4", k, lat);
      end
    end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL directed_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_backpressure();
    logic [31:0] a, b;
    logic [62:0] p0;
    int guard;
    a = $urandom; b = $urandom;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; in_a = $urandom; in_b = $urandom;
    n_checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_mul_state busy=%b in_ready=%b want busy=1 in_ready=0", busy, in_ready);
    end
    guard = 0;
    while (!out_valid && guard < 16) begin @(posedge clk); #1; guard++; end
    p0 = out_p;
    n_checks++; if (p0 !== ref_clmul(a, b)) begin
      n_fail++; $display("FAIL bp_product got %h want %h", p0, ref_clmul(a, b));
    end
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || out_p !== p0 || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d valid=%b p=%h in_ready=%b want valid=1 p=%h in_ready=0",
                 c, out_valid, out_p, in_ready, p0);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_fail++; $display("FAIL bp_release_%0d valid=%b busy=%b want 0 0", c, out_valid, busy);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    localparam int N = 1000;
    logic [62:0] exp_q [$];
    logic [62:0] e;
    logic [31:0] a, b;
    int sent, recv, cyc, last_acc;
    bit acc;
    sent = 0; recv = 0; cyc = 0; last_acc = -1;
    a = $urandom; b = $urandom;
    in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
    while (recv < N && cyc < N * 4 + 64) begin
      if (out_valid) begin
        recv++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 63'd0;
        n_checks++;
        if (out_p !== e) begin
          n_fail++; $display("FAIL b2b_product_%0d got %h want %h", recv, out_p, e);
        end
      end
      acc = in_valid && in_ready;
      if (acc) begin
        exp_q.push_back(ref_clmul(a, b));
        sent++;
        if (last_acc >= 0) begin
          n_checks++;
          if (cyc - last_acc != 4) begin
            n_fail++; $display("FAIL b2b_accept_gap got %0d want 4", cyc - last_acc);
          end
        end
        last_acc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        if (sent == N) in_valid = 1'b0;
        else begin a = $urandom; b = $urandom; in_a = a; in_b = b; end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0;
    n_checks++;
    if (recv != N || exp_q.size() != 0) begin
      n_fail++; $display("FAIL b2b_count received %0d pending %0d want %0d 0", recv, exp_q.size(), N);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    logic [31:0] a, b;
    logic [62:0] p;
    int lat;
    bit seen;
    in_a = $urandom; in_b = $urandom; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_p !== 63'd0) begin
      n_fail++;
      $display("FAIL rst_mid_state valid=%b in_ready=%b busy=%b p=%h want 0 1 0 0",
               out_valid, in_ready, busy, out_p);
    end
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    n_checks++; if (seen) begin n_fail++; $display("FAIL rst_mid_no_pulse got 1 want 0"); end
    a = $urandom; b = $urandom;
    run_op(a, b, p, lat);
    n_checks++; if (p !== ref_clmul(a, b)) begin
      n_fail++; $display("FAIL rst_mid_after got %h want %h", p, ref_clmul(a, b));
    end
    n_checks++; if (lat != 4) begin n_fail++; $display("FAIL rst_mid_latency got %0d want 4", lat); end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0; out_ready = 1'b0;
    n_checks = 0; n_fail = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
